// File: rtl/irq_pkg.sv
// irq_pkg: shared defaults and FSM state encoding for the interrupt request controller
package irq_pkg;
  localparam int IRQ_NUM_SRC = 8;
  localparam int IRQ_ID_W = 3;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SIGNAL  = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;
endpackage

// File: rtl/irq_priority_encoder.sv
// irq_priority_encoder: eligible vector -> lowest set index (id) and any-set flag; ports: eligible in, id/any out
module irq_priority_encoder #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] eligible,
  output logic [W-1:0] id,
  output logic         any
);
  always_comb begin
    id = '0;
    for (int i = N - 1; i >= 0; i--) id = eligible[i] ? W'(i) : id;
    any = |eligible;
  end
endmodule

// File: rtl/irq_request_controller.sv
// irq_request_controller: edge-latched IRQ sources, mask, priority arbitration and CPU request FSM; ports: clk/reset, irq_src, mask write, return_from_isr in; interrupt_req, irq_id, in_service, pending, irq_mask out
module irq_request_controller
  import irq_pkg::*;
#(
  parameter int NUM_SRC = IRQ_NUM_SRC,
  parameter int ID_W = IRQ_ID_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               mask_wr_en,
  input  logic [NUM_SRC-1:0] mask_wr_data,
  input  logic               return_from_isr,
  output logic               interrupt_req,
  output logic [ID_W-1:0]    irq_id,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] irq_mask
);
  irq_state_t state, next_state;
  logic [NUM_SRC-1:0] src_q, events, clr;
  logic [ID_W-1:0] win_id;
  logic win_any;
  irq_priority_encoder #(.N(NUM_SRC), .W(ID_W)) u_enc (
    .eligible(pending & irq_mask),
    .id(win_id),
    .any(win_any)
  );
  assign events = irq_src & ~src_q;
  // a clear and a fresh event on the same bit resolve to set because events is OR'd in last
  assign clr = (state == SERVICE && return_from_isr) ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << irq_id) : '0;
  assign interrupt_req = state == SIGNAL;
  assign in_service = state != IDLE;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = win_any ? SIGNAL : IDLE;
      SIGNAL:  next_state = SERVICE;
      SERVICE: next_state = return_from_isr ? IDLE : SERVICE;
      default: next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    src_q <= irq_src;
    if (reset) begin
      state <= IDLE;
      pending <= '0;
      irq_mask <= '0;
      irq_id <= '0;
    end else begin
      state <= next_state;
      pending <= (pending & ~clr) | events;
      if (mask_wr_en) irq_mask <= mask_wr_data;
      if (state == IDLE && win_any) irq_id <= win_id;
    end
  end
endmodule

// File: tb/tb_irq_request_controller.sv
// tb_irq_request_controller: directed stimulus with a request scoreboard for irq_request_controller
module tb_irq_request_controller;
  logic clk = 0, reset = 1, mask_wr_en = 0, return_from_isr = 0;
  logic [7:0] irq_src = 0, mask_wr_data = 0;
  logic interrupt_req, in_service;
  logic [2:0] irq_id;
  logic [7:0] pending, irq_mask;
  int tests = 0, fails = 0;
  int exp_q[$];
  irq_request_controller dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .mask_wr_en(mask_wr_en),
    .mask_wr_data(mask_wr_data), .return_from_isr(return_from_isr),
    .interrupt_req(interrupt_req), .irq_id(irq_id), .in_service(in_service),
    .pending(pending), .irq_mask(irq_mask)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (interrupt_req) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_req: irq_id=%0d, required no request", irq_id);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (irq_id !== 3'(e) || in_service !== 1'b1) begin
          fails++;
          $display("FAIL req_id: irq_id=%0d in_service=%b, required irq_id=%0d in_service=1", irq_id, in_service, e);
        end
      end
    end
  end
  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask
  task automatic write_mask(logic [7:0] m);
    mask_wr_en = 1;
    mask_wr_data = m;
    tick();
    mask_wr_en = 0;
  endtask
  task automatic ret();
    return_from_isr = 1;
    tick();
    return_from_isr = 0;
  endtask
  task automatic check_reset_state(string tag);
    check({tag, "_req"}, 8'(interrupt_req), 8'h00);
    check({tag, "_insvc"}, 8'(in_service), 8'h00);
    check({tag, "_pending"}, pending, 8'h00);
    check({tag, "_mask"}, irq_mask, 8'h00);
    check({tag, "_id"}, 8'(irq_id), 8'h00);
  endtask
  initial begin
    tick(2);
    check_reset_state("rst");
    reset = 0;
    write_mask(8'hFF);
    check("mask_ff", irq_mask, 8'hFF);
    exp_q.push_back(5);
    irq_src = 8'h20;
    tick();
    check("p5_pending", pending, 8'h20);
    check("p5_noreq_yet", 8'(interrupt_req), 8'h00);
    tick();
    check("p5_req", 8'(interrupt_req), 8'h01);
    check("p5_id", 8'(irq_id), 8'd5);
    check("p5_insvc", 8'(in_service), 8'h01);
    tick();
    check("p5_req_one_cycle", 8'(interrupt_req), 8'h00);
    check("p5_insvc_svc", 8'(in_service), 8'h01);
    ret();
    check("p5_done_insvc", 8'(in_service), 8'h00);
    check("p5_done_pending", pending, 8'h00);
    irq_src = 8'h00;
    exp_q.push_back(2);
    exp_q.push_back(6);
    irq_src = 8'h44;
    tick();
    check("p26_pending", pending, 8'h44);
    tick();
    check("p26_id2", 8'(irq_id), 8'd2);
    tick();
    ret();
    check("p26_after_ret", pending, 8'h40);
    check("p26_idle_gap", 8'(in_service), 8'h00);
    tick();
    check("p26_req6", 8'(interrupt_req), 8'h01);
    check("p26_id6", 8'(irq_id), 8'd6);
    tick();
    ret();
    irq_src = 8'h00;
    check("p26_clear", pending, 8'h00);
    write_mask(8'h00);
    irq_src = 8'h08;
    tick(3);
    check("m3_pending", pending, 8'h08);
    check("m3_noreq", 8'(in_service), 8'h00);
    exp_q.push_back(3);
    write_mask(8'h08);
    tick();
    check("m3_req", 8'(interrupt_req), 8'h01);
    check("m3_id", 8'(irq_id), 8'd3);
    tick();
    ret();
    irq_src = 8'h00;
    write_mask(8'hFF);
    exp_q.push_back(1);
    irq_src = 8'h02;
    tick(3);
    irq_src = 8'h00;
    tick();
    exp_q.push_back(1);
    irq_src = 8'h02;
    ret();
    check("r1_pending_kept", pending, 8'h02);
    check("r1_idle", 8'(in_service), 8'h00);
    tick();
    check("r1_req", 8'(interrupt_req), 8'h01);
    check("r1_id", 8'(irq_id), 8'd1);
    tick();
    ret();
    irq_src = 8'h00;
    check("r1_clear", pending, 8'h00);
    irq_src = 8'h01;
    reset = 1;
    tick(2);
    reset = 0;
    write_mask(8'hFF);
    tick(3);
    check("held_no_event", pending, 8'h00);
    check("held_noreq", 8'(in_service), 8'h00);
    ret();
    check("ret_idle_ignored", 8'(in_service), 8'h00);
    irq_src = 8'h00;
    exp_q.push_back(3);
    irq_src = 8'h08;
    tick(3);
    check("rs_in_svc", 8'(in_service), 8'h01);
    reset = 1;
    tick();
    check_reset_state("rs");
    reset = 0;
    irq_src = 8'h00;
    tick(4);
    check("rs_quiet", 8'(in_service), 8'h00);
    check("scoreboard_empty", 8'(exp_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
